seg_display_scan: RTL and testbench



---
 rtl/seg_pkg.sv | 29 ++
 rtl/hex_to_seg.sv | 32 +++
 rtl/seg_display_scan.sv | 123 ++++++++++++
 tb/tb_seg_display_scan.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and segment constants for the 7-segment scanner
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low a..g (bit0 = a, bit6 = g); b and d are lowercase shapes
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - hex nibble to active-low 7-segment pattern
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_OFF;
        case (nibble)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - multiplexed common-anode display scanner with frame latch
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS       = 3,
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   seg_digits,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  lz_blank,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    scan_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [DIGITS-1:0]   dpm_q, dpm_d;

    logic [6:0]          seg_n_q, seg_n_d;
    logic                dp_n_q, dp_n_d;
    logic [DIGITS-1:0]   an_n_q, an_n_d;
    logic                frame_tick_q, frame_tick_d;

    logic [3:0]          nibble_d;
    logic [6:0]          seg_dec;
    logic                upper_zero;
    logic                lit_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        disp_d       = disp_q;
        dpm_d        = dpm_q;
        frame_tick_d = 1'b0;

        if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_ON;
                    // Latch the whole word only at the start of digit 0 so a frame never tears
                    if (idx_q == '0) begin
                        disp_d       = seg_digits;
                        dpm_d        = dp_mask;
                        frame_tick_d = 1'b1;
                    end
                end
            end
            ST_ON: begin
                if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
                    state_d = ST_BLANK;
                    idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe
    always_comb begin
        nibble_d   = disp_d[4*idx_d +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (i >= int'(idx_d) && disp_d[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        lit_d  = (state_d == ST_ON) && !(lz_blank && idx_d != '0 && upper_zero);
        an_n_d  = lit_d ? ~(DIGITS'(1) << idx_d) : '1;
        seg_n_d = lit_d ? seg_dec : SEG_OFF;
        dp_n_d  = lit_d ? ~dpm_d[idx_d] : 1'b1;
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble_d),
        .seg_n  (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            dpm_q        <= '0;
            seg_n_q      <= SEG_OFF;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            dpm_q        <= dpm_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - self-checking bench for seg_display_scan
module tb_seg_display_scan;

    localparam int DIGITS = 3;
    localparam int DC     = 8;
    localparam int BC     = 2;
    localparam int FRAME  = DIGITS * DC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] seg_digits = '0;
    logic [2:0]  dp_mask = '0;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [2:0]  an_n;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tbl [16];

    // Reference model: cycles since the last reset edge plus the word captured at each frame start
    int          k = 0;
    logic [11:0] m_disp = '0;
    logic [2:0]  m_dp = '0;
    logic        m_lz = 1'b0;

    seg_display_scan #(
        .DIGITS       (DIGITS),
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_digits (seg_digits),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        m_lz <= lz_blank;
        if (!rst_n) begin
            k      <= 0;
            m_disp <= '0;
            m_dp   <= '0;
        end else begin
            k <= k + 1;
            if ((k + 1) % FRAME == BC) begin
                m_disp <= seg_digits;
                m_dp   <= dp_mask;
            end
        end
    end

    task automatic check_cycle(input string tag);
        int         pos, slot;
        bit         on, sup;
        logic [3:0] nib;
        logic [11:0] upper;
        logic [2:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp, exp_tick;
        pos   = k % DC;
        slot  = (k / DC) % DIGITS;
        on    = (pos >= BC);
        upper = m_disp >> (4 * slot);
        nib   = upper[3:0];
        sup   = m_lz && (slot > 0) && (upper == 12'h000);
        exp_tick = on && (k % FRAME == BC);
        exp_an   = (on && !sup) ? ~(3'b001 << slot) : 3'b111;
        exp_seg  = seg_tbl[nib];
        exp_dp   = ~m_dp[slot];

        tests++;
        assert (an_n === exp_an) else begin
            fails++;
            $error("FAIL %s an_n k=%0d got=%b exp=%b", tag, k, an_n, exp_an);
        end
        tests++;
        assert (frame_tick === exp_tick) else begin
            fails++;
            $error("FAIL %s frame_tick k=%0d got=%b exp=%b", tag, k, frame_tick, exp_tick);
        end
        if (!on) begin
            tests++;
            assert (seg_n === 7'h7F && dp_n === 1'b1) else begin
                fails++;
                $error("FAIL %s blank seg/dp k=%0d got=%h/%b exp=7f/1", tag, k, seg_n, dp_n);
            end
        end else if (!sup) begin
            tests++;
            assert (seg_n === exp_seg) else begin
                fails++;
                $error("FAIL %s seg_n k=%0d got=%h exp=%h", tag, k, seg_n, exp_seg);
            end
            tests++;
            assert (dp_n === exp_dp) else begin
                fails++;
                $error("FAIL %s dp_n k=%0d got=%b exp=%b", tag, k, dp_n, exp_dp);
            end
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_cycle(tag);
        end
    endtask

    task automatic run_to_phase(input int phase, input string tag);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            check_cycle(tag);
            guard++;
        end while ((k % FRAME) != phase && guard < 2 * FRAME);
        tests++;
        assert ((k % FRAME) == phase) else begin
            fails++;
            $error("FAIL %s phase_timeout got=%0d exp=%0d", tag, k % FRAME, phase);
        end
    endtask

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset held 3 cycles
        @(negedge clk);
        run(3, "reset");
        tests++;
        assert (an_n === 3'b111 && seg_n === 7'h7F && dp_n === 1'b1 && frame_tick === 1'b0) else begin
            fails++;
            $error("FAIL reset_outputs got an=%b seg=%h dp=%b tick=%b exp=111/7f/1/0", an_n, seg_n, dp_n, frame_tick);
        end

        // Static value, first ON window after release carries frame_tick
        seg_digits = 12'h500;
        rst_n = 1'b1;
        run(2, "release");
        tests++;
        assert (an_n === 3'b110 && frame_tick === 1'b1) else begin
            fails++;
            $error("FAIL first_on got an=%b tick=%b exp=110/1", an_n, frame_tick);
        end
        run(2 * FRAME, "static");

        // Tear-free latch: change during digit 1 ON
        seg_digits = 12'h100;
        run_to_phase(BC, "tear_a");
        run_to_phase(DC + 3, "tear_b");
        seg_digits = 12'h501;
        run(2 * FRAME, "tear");

        // Leading-zero blanking
        lz_blank = 1'b1;
        seg_digits = 12'h001;
        run(2 * FRAME, "lz001");
        seg_digits = 12'h010;
        run(2 * FRAME, "lz010");
        lz_blank = 1'b0;

        // Mid-frame reset during digit 1 ON
        seg_digits = 12'hA7C;
        run_to_phase(DC + 4, "midrst_a");
        rst_n = 1'b0;
        seg_digits = 12'h3E9;
        run(2, "midrst");
        rst_n = 1'b1;
        run(2 * FRAME, "midrst_after");

        // Decode sweep on digit 0, then decimal point on digit 1
        for (int n = 0; n < 16; n++) begin
            seg_digits = 12'(n);
            run(FRAME, "sweep");
        end
        dp_mask = 3'b010;
        seg_digits = 12'h888;
        run(2 * FRAME, "dp");

        // Randomized traffic with occasional resets and live lz changes
        for (int r = 0; r < 60; r++) begin
            seg_digits = 12'($urandom);
            if ($urandom_range(0, 2) == 0) seg_digits[11:4] = '0;
            dp_mask  = 3'($urandom);
            lz_blank = 1'($urandom);
            rst_n    = ($urandom_range(0, 19) != 0);
            run($urandom_range(1, 30), "random");
            rst_n = 1'b1;
        end
        run(2 * FRAME, "tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
